// File: rtl/mips_mem_pkg.sv
// Shared definitions for the cache-block memory arbiter: FSM encoding,
// default bus widths and the block-offset helper.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int BLK_W_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Number of byte-offset bits inside one block.
  function automatic int blk_off_w(input int blk_w);
    return $clog2(blk_w / 8);
  endfunction

endpackage

// File: rtl/mem_block_arbiter_if.sv
// Cache-side and memory-side signals of the block arbiter.
// The slave view belongs to the arbiter; master is the cache/memory environment.
interface mem_block_arbiter_if #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W_DEF,
  parameter int BLK_W  = mips_mem_pkg::BLK_W_DEF
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BLK_W-1:0]  d_wdata;
  logic              i_done;
  logic [BLK_W-1:0]  i_rdata;
  logic              d_done;
  logic [BLK_W-1:0]  d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_ready;
  logic              freeze;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, freeze
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, freeze
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select for the shared block port: D has priority, but I is forced
// once D has won STARVE_MAX times in a row while I was waiting.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);
  logic [3:0] starve_cnt;
  logic       starved;

  always_comb begin
    starved = (starve_cnt >= 4'(STARVE_MAX));
    grant_d = arb_en & d_req & (~i_req | ~starved);
    grant_i = arb_en & i_req & ~grant_d;
  end

  // Only D wins that leave I behind extend the streak; any other grant clears it.
  always_ff @(posedge CLK) begin
    if (RESET)                 starve_cnt <= '0;
    else if (grant_d & i_req)  starve_cnt <= starve_cnt + 4'd1;
    else if (grant_i | grant_d) starve_cnt <= '0;
  end
endmodule

// File: rtl/mem_block_arbiter.sv
// Serialises I-cache fills and D-cache fills/writebacks onto one main-memory
// block port, and stalls the pipeline while any requester is waiting.
module mem_block_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BLK_W      = BLK_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic CLK,
  input logic RESET,
  mem_block_arbiter_if.slave bus
);
  localparam int                OFF_W    = blk_off_w(BLK_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = {ADDR_W{1'b1}} << OFF_W;

  arb_state_e        state;
  logic              grant_i, grant_d;
  logic              mem_req, mem_we, i_done, d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata, i_rdata, d_rdata;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .CLK     (CLK),
    .RESET   (RESET),
    .arb_en  (state == IDLE),
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: if (grant_i | grant_d) begin
          state    <= grant_i ? BUSY_I : BUSY_D;
          mem_req  <= 1'b1;
          mem_addr <= (grant_i ? bus.i_addr : bus.d_addr) & OFF_MASK;
          mem_we   <= grant_d & bus.d_we;
          if (grant_d & bus.d_we) mem_wdata <= bus.d_wdata;
        end
        BUSY_I: if (bus.mem_ready) begin
          i_rdata <= bus.mem_rdata;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          i_done  <= 1'b1;
          state   <= DONE;
        end
        BUSY_D: if (bus.mem_ready) begin
          if (!mem_we) d_rdata <= bus.mem_rdata;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          d_done  <= 1'b1;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.i_done    = i_done;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_done    = d_done;
  assign bus.d_rdata   = d_rdata;
  // Done flags are registered, so freeze drops in the pulse cycle itself.
  assign bus.freeze    = (bus.i_req & ~i_done) | (bus.d_req & ~d_done);
endmodule
